// File: rtl/spi_master_scheduler.sv
// Round-robin scheduler sharing one SPI_MASTER byte engine between NUM_REQ requesters.
// Runs chip-select-framed multi-byte transactions with programmable CS setup/hold and a per-byte timeout.
module spi_master_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int DATAWIDTH_BUS = 8,
  parameter int LEN_WIDTH     = 4,
  parameter int CS_SETUP      = 2,
  parameter int CS_HOLD       = 2,
  parameter int TIMEOUT       = 255
) (
  input  logic                               SPI_MASTER_CLOCK_50,
  input  logic                               SPI_MASTER_RESET_InHigh,
  input  logic [NUM_REQ-1:0]                 SPI_SCHEDULER_req_In,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]       SPI_SCHEDULER_len_In,
  input  logic [NUM_REQ*DATAWIDTH_BUS-1:0]   SPI_SCHEDULER_txData_In,
  output logic [NUM_REQ-1:0]                 SPI_SCHEDULER_txPop_Out,
  output logic [NUM_REQ-1:0]                 SPI_SCHEDULER_grant_Out,
  output logic [DATAWIDTH_BUS-1:0]           SPI_SCHEDULER_rxData_Out,
  output logic [NUM_REQ-1:0]                 SPI_SCHEDULER_rxValid_Out,
  output logic [NUM_REQ-1:0]                 SPI_SCHEDULER_done_Out,
  output logic [NUM_REQ-1:0]                 SPI_SCHEDULER_error_Out,
  output logic [NUM_REQ-1:0]                 SPI_SCHEDULER_SS_n_Out,
  output logic                               SPI_SCHEDULER_start_Out,
  output logic [DATAWIDTH_BUS-1:0]           SPI_SCHEDULER_data_Out,
  input  logic                               SPI_SCHEDULER_newData_In,
  input  logic [DATAWIDTH_BUS-1:0]           SPI_SCHEDULER_data_In
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {IDLE, ARB, SETUP, LOAD, START, WAIT, HOLD, DONE} state_t;

  state_t                   st, nx;
  logic [7:0]               cnt;
  logic [NUM_REQ-1:0]       grant;
  logic [IW-1:0]            gidx, last, win;
  logic                     found;
  logic [LEN_WIDTH-1:0]     len_q, bcnt;
  logic                     err_q;
  logic                     ss_active;
  logic [LEN_WIDTH-1:0]     len_a [NUM_REQ];
  logic [DATAWIDTH_BUS-1:0] tx_a  [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign len_a[i] = SPI_SCHEDULER_len_In[i*LEN_WIDTH +: LEN_WIDTH];
    assign tx_a[i]  = SPI_SCHEDULER_txData_In[i*DATAWIDTH_BUS +: DATAWIDTH_BUS];
  end

  // Scan downward so the nearest requester after the last grant wins.
  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    win   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = int'(last) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (SPI_SCHEDULER_req_In[IW'(j)]) begin
        found = 1'b1;
        win   = IW'(j);
      end
    end
  end

  always_ff @(posedge SPI_MASTER_CLOCK_50 or posedge SPI_MASTER_RESET_InHigh)
    if (SPI_MASTER_RESET_InHigh) st <= IDLE;
    else                         st <= nx;

  always_comb begin
    nx = st;
    case (st)
      IDLE:  if (|SPI_SCHEDULER_req_In) nx = ARB;
      ARB:   nx = found ? SETUP : IDLE;
      SETUP: if (cnt == 8'(CS_SETUP - 1)) nx = LOAD;
      LOAD:  nx = START;
      START: nx = WAIT;
      WAIT: begin
        if (SPI_SCHEDULER_newData_In) nx = (bcnt == len_q) ? HOLD : LOAD;
        else if (cnt == 8'(TIMEOUT - 1)) nx = HOLD;
      end
      HOLD:  if (cnt == 8'(CS_HOLD - 1)) nx = DONE;
      DONE:  nx = IDLE;
      default: nx = IDLE;
    endcase
  end

  // cnt restarts on every state change, so it times SETUP, WAIT and HOLD alike.
  always_ff @(posedge SPI_MASTER_CLOCK_50 or posedge SPI_MASTER_RESET_InHigh)
    if (SPI_MASTER_RESET_InHigh) begin
      cnt                       <= '0;
      grant                     <= '0;
      gidx                      <= '0;
      last                      <= IW'(NUM_REQ - 1);
      len_q                     <= '0;
      bcnt                      <= '0;
      err_q                     <= 1'b0;
      SPI_SCHEDULER_data_Out    <= '0;
      SPI_SCHEDULER_rxData_Out  <= '0;
      SPI_SCHEDULER_rxValid_Out <= '0;
    end else begin
      cnt                       <= (nx != st) ? 8'd0 : cnt + 8'd1;
      SPI_SCHEDULER_rxValid_Out <= '0;
      case (st)
        ARB: if (found) begin
          grant <= NUM_REQ'(1) << win;
          gidx  <= win;
          len_q <= len_a[win];
          bcnt  <= '0;
          err_q <= 1'b0;
        end
        LOAD: SPI_SCHEDULER_data_Out <= tx_a[gidx];
        WAIT: begin
          if (SPI_SCHEDULER_newData_In) begin
            SPI_SCHEDULER_rxData_Out  <= SPI_SCHEDULER_data_In;
            SPI_SCHEDULER_rxValid_Out <= grant;
            if (bcnt != len_q) bcnt <= bcnt + 1'b1;
          end else if (cnt == 8'(TIMEOUT - 1)) err_q <= 1'b1;
        end
        DONE: begin
          grant <= '0;
          last  <= gidx;
        end
        default: ;
      endcase
    end

  assign ss_active               = (st == SETUP) || (st == LOAD) || (st == START) ||
                                   (st == WAIT)  || (st == HOLD);
  assign SPI_SCHEDULER_SS_n_Out  = ss_active ? ~grant : '1;
  assign SPI_SCHEDULER_grant_Out = grant;
  assign SPI_SCHEDULER_start_Out = (st == START);
  assign SPI_SCHEDULER_txPop_Out = (st == LOAD) ? grant : '0;
  assign SPI_SCHEDULER_done_Out  = (st == DONE) ? grant : '0;
  assign SPI_SCHEDULER_error_Out = (st == DONE && err_q) ? grant : '0;
endmodule

// File: tb/tb_spi_master_scheduler.sv
// Bench for spi_master_scheduler: requester queues and a randomized SPI master model drive the DUT,
// transaction-level expectations (round-robin order, byte counts, latencies) come from a reference model.
module tb_spi_master_scheduler;
  localparam int N = 4, DW = 8, LW = 4, CSS = 2, CSH = 2, TMO = 255;

  logic clk = 1'b0, rst = 1'b1;
  always #10 clk = ~clk;

  logic [N-1:0]    req = '0;
  logic [N*LW-1:0] len = '0;
  logic [N*DW-1:0] txd = '0;
  logic [N-1:0]    tx_pop, grant, rx_vld, done, err, ss_n;
  logic [DW-1:0]   rx_data, mosi_data, miso = '0;
  logic            start, new_d = 1'b0;

  spi_master_scheduler #(.NUM_REQ(N), .DATAWIDTH_BUS(DW), .LEN_WIDTH(LW),
                         .CS_SETUP(CSS), .CS_HOLD(CSH), .TIMEOUT(TMO)) dut (
    .SPI_MASTER_CLOCK_50(clk), .SPI_MASTER_RESET_InHigh(rst),
    .SPI_SCHEDULER_req_In(req), .SPI_SCHEDULER_len_In(len), .SPI_SCHEDULER_txData_In(txd),
    .SPI_SCHEDULER_txPop_Out(tx_pop), .SPI_SCHEDULER_grant_Out(grant),
    .SPI_SCHEDULER_rxData_Out(rx_data), .SPI_SCHEDULER_rxValid_Out(rx_vld),
    .SPI_SCHEDULER_done_Out(done), .SPI_SCHEDULER_error_Out(err), .SPI_SCHEDULER_SS_n_Out(ss_n),
    .SPI_SCHEDULER_start_Out(start), .SPI_SCHEDULER_data_Out(mosi_data),
    .SPI_SCHEDULER_newData_In(new_d), .SPI_SCHEDULER_data_In(miso));

  int checks = 0, failures = 0, cyc = 0;
  logic [DW-1:0] tx_mem [N][64];
  int tx_head [N], tx_tail [N];
  bit pop_pend [N];
  logic [DW-1:0] pop_log [$], resp_log [$];
  int grant_log [$];
  int pop_cnt [N], rx_cnt [N], done_cnt [N], err_cnt [N];
  int start_cnt, done_total, data_err, rx_err, ss_err, gap_err;
  int last_start_cyc, last_done_cyc, first_grant_cyc, stop_target;
  bit keep_req = 0, drop_on_grant = 0;
  bit m_pend = 0, m_silent = 0, m_loop = 1, m_noise = 0;
  int m_delay = 0, m_dmax = 0, m_fix = -1;
  logic [DW-1:0] m_cap;
  logic [N-1:0] prev_grant = '0;
  int model_last = N - 1;

  function automatic int rr_next(int lst, logic [N-1:0] mask);
    for (int k = 1; k <= N; k++) if (mask[(lst + k) % N]) return (lst + k) % N;
    return -1;
  endfunction

  function automatic int oh_idx(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic drive_tx();
    for (int i = 0; i < N; i++)
      txd[i*DW +: DW] = (tx_head[i] != tx_tail[i]) ? tx_mem[i][tx_head[i]] : '0;
  endtask

  task automatic clear_stats();
    for (int i = 0; i < N; i++) begin
      tx_head[i] = 0; tx_tail[i] = 0; pop_pend[i] = 0;
      pop_cnt[i] = 0; rx_cnt[i] = 0; done_cnt[i] = 0; err_cnt[i] = 0;
    end
    pop_log.delete(); resp_log.delete(); grant_log.delete();
    start_cnt = 0; done_total = 0; data_err = 0; rx_err = 0; ss_err = 0; gap_err = 0;
    last_start_cyc = -100; last_done_cyc = -100; first_grant_cyc = -100; stop_target = 1 << 30;
    m_pend = 0; m_silent = 0; m_noise = 0; m_loop = 1; m_dmax = 0; m_fix = -1;
    keep_req = 0; drop_on_grant = 0;
    drive_tx();
  endtask

  task automatic load_req(input int i, input int l, input bit rnd, input logic [DW-1:0] base);
    len[i*LW +: LW] = LW'(l);
    for (int b = 0; b <= l; b++) begin
      tx_mem[i][tx_tail[i]] = rnd ? DW'($urandom) : base + DW'(b);
      tx_tail[i]++;
    end
    drive_tx();
  endtask

  // One cycle of requester + master behaviour: observe at negedge, then drive next inputs.
  task automatic step();
    bit started_now;
    started_now = 0;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < N; i++) if (pop_pend[i]) begin tx_head[i]++; pop_pend[i] = 0; end
    if (!$onehot0(grant)) ss_err++;
    if (grant != 0 && done == 0 && ss_n !== ~grant) ss_err++;
    if ((grant == 0 || done != 0) && ss_n !== '1) ss_err++;
    if ((err & ~done) != 0) ss_err++;
    if (grant != 0 && grant != prev_grant) begin
      grant_log.push_back(oh_idx(grant));
      first_grant_cyc = cyc;
      if (drop_on_grant) req = '0;
    end
    prev_grant = grant;
    for (int i = 0; i < N; i++) if (tx_pop[i]) begin
      if (!grant[i]) data_err++;
      pop_log.push_back(tx_mem[i][tx_head[i]]);
      pop_pend[i] = 1;
      pop_cnt[i]++;
    end
    if (start) begin
      start_cnt++;
      if (cyc - last_start_cyc < 3 || ss_n == '1) gap_err++;
      last_start_cyc = cyc;
      if (pop_log.size() == 0) data_err++;
      else if (mosi_data !== pop_log.pop_front()) data_err++;
      m_pend = 1; started_now = 1; m_cap = mosi_data;
      m_delay = m_silent ? (1 << 30) : (m_fix >= 0 ? m_fix : $urandom_range(m_dmax, 0));
    end
    if (rx_vld != 0) begin
      if (rx_vld !== grant || !$onehot(rx_vld)) rx_err++;
      else rx_cnt[oh_idx(rx_vld)]++;
      if (resp_log.size() == 0) rx_err++;
      else if (rx_data !== resp_log.pop_front()) rx_err++;
    end
    if (done != 0) begin
      last_done_cyc = cyc;
      done_total++;
      if (done !== grant) ss_err++;
      for (int i = 0; i < N; i++) begin
        if (done[i]) begin done_cnt[i]++; if (!keep_req) req[i] = 1'b0; end
        if (err[i]) err_cnt[i]++;
      end
    end
    if (done_total >= stop_target) req = '0;
    new_d = 1'b0;
    miso  = DW'($urandom);
    if (m_pend && !started_now) begin
      if (m_delay == 0) begin
        new_d = 1'b1;
        if (m_loop) miso = m_cap;
        resp_log.push_back(miso);
        m_pend = 0;
      end else m_delay--;
    end else if (!m_pend && m_noise && $urandom_range(3, 0) == 0) new_d = 1'b1;
    drive_tx();
  endtask

  task automatic run_until(input int target, input int budget, output bit ok);
    ok = 0;
    stop_target = target;
    for (int k = 0; k < budget; k++) begin
      step();
      if (done_total >= target) begin ok = 1; break; end
    end
    req = '0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    repeat (2) step();
    checks++; if (ss_n !== 4'b1111) begin failures++; $display("FAIL rst_ss got=%b exp=1111", ss_n); end
    checks++; if (grant !== 4'b0) begin failures++; $display("FAIL rst_grant got=%b exp=0000", grant); end
    checks++; if ({start, tx_pop, rx_vld, done, err} !== '0) begin failures++;
      $display("FAIL rst_strobes got=%b exp=0", {start, tx_pop, rx_vld, done, err}); end
    checks++; if (mosi_data !== 8'h00 || rx_data !== 8'h00) begin failures++;
      $display("FAIL rst_data got=%h/%h exp=00/00", mosi_data, rx_data); end
    rst = 1'b0;
    repeat (2) step();
    checks++; if (ss_n !== 4'b1111 || grant !== 4'b0) begin failures++;
      $display("FAIL post_rst_idle got=%b/%b exp=1111/0000", ss_n, grant); end
  endtask

  task automatic test_fairness();
    bit ok;
    int exp_q [$];
    clear_stats();
    for (int i = 0; i < N; i++) begin load_req(i, 0, 1, 0); load_req(i, 0, 1, 0); end
    keep_req = 1;
    req = '1;
    run_until(5, 3000, ok);
    for (int t = 0; t < 5; t++) begin model_last = rr_next(model_last, '1); exp_q.push_back(model_last); end
    checks++; if (!ok) begin failures++; $display("FAIL fair_timeout got=%0d done exp=5", done_total); end
    checks++; if (grant_log != exp_q) begin failures++;
      $display("FAIL fair_order got=%p exp=%p", grant_log, exp_q); end
    checks++; if (ss_err + gap_err + data_err + rx_err != 0) begin failures++;
      $display("FAIL fair_protocol got ss=%0d gap=%0d data=%0d rx=%0d exp=0", ss_err, gap_err, data_err, rx_err); end
  endtask

  task automatic test_single();
    bit ok;
    int req_cyc;
    clear_stats();
    load_req(0, 0, 0, 8'hA5);
    req[0] = 1'b1;
    req_cyc = cyc;
    run_until(1, 200, ok);
    model_last = 0;
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout got=%0d done exp=1", done_total); end
    checks++; if (first_grant_cyc - req_cyc != 2) begin failures++;
      $display("FAIL single_grant_lat got=%0d exp=2", first_grant_cyc - req_cyc); end
    checks++; if (start_cnt != 1 || last_start_cyc - req_cyc != 3 + CSS) begin failures++;
      $display("FAIL single_start got cnt=%0d lat=%0d exp cnt=1 lat=%0d", start_cnt, last_start_cyc - req_cyc, 3 + CSS); end
    checks++; if (last_done_cyc - last_start_cyc != 2 + CSH) begin failures++;
      $display("FAIL single_done_lat got=%0d exp=%0d", last_done_cyc - last_start_cyc, 2 + CSH); end
    checks++; if (rx_cnt[0] != 1 || rx_data !== 8'hA5 || pop_cnt[0] != 1) begin failures++;
      $display("FAIL single_rx got cnt=%0d data=%h pops=%0d exp 1/a5/1", rx_cnt[0], rx_data, pop_cnt[0]); end
    checks++; if (done_cnt[0] != 1 || err_cnt[0] != 0 || ss_n !== 4'b1111) begin failures++;
      $display("FAIL single_end got done=%0d err=%0d ss=%b exp 1/0/1111", done_cnt[0], err_cnt[0], ss_n); end
    checks++; if (ss_err + gap_err + data_err + rx_err != 0) begin failures++;
      $display("FAIL single_protocol got ss=%0d gap=%0d data=%0d rx=%0d exp=0", ss_err, gap_err, data_err, rx_err); end
  endtask

  task automatic test_burst();
    bit ok;
    clear_stats();
    m_dmax = 3;
    load_req(2, 3, 0, 8'h01);
    req[2] = 1'b1;
    run_until(1, 400, ok);
    model_last = 2;
    checks++; if (!ok || done_cnt[2] != 1) begin failures++; $display("FAIL burst_done got=%0d exp=1", done_cnt[2]); end
    checks++; if (pop_cnt[2] != 4 || start_cnt != 4 || rx_cnt[2] != 4) begin failures++;
      $display("FAIL burst_counts got pop=%0d start=%0d rx=%0d exp=4", pop_cnt[2], start_cnt, rx_cnt[2]); end
    checks++; if (ss_err + gap_err + data_err + rx_err != 0) begin failures++;
      $display("FAIL burst_protocol got ss=%0d gap=%0d data=%0d rx=%0d exp=0", ss_err, gap_err, data_err, rx_err); end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_stats();
    m_silent = 1;
    load_req(1, 0, 1, 0);
    req[1] = 1'b1;
    run_until(1, 800, ok);
    m_pend = 0; m_silent = 0;
    model_last = 1;
    checks++; if (!ok || done_cnt[1] != 1 || err_cnt[1] != 1) begin failures++;
      $display("FAIL tmo_flags got done=%0d err=%0d exp 1/1", done_cnt[1], err_cnt[1]); end
    checks++; if (last_done_cyc - last_start_cyc != TMO + CSH + 1) begin failures++;
      $display("FAIL tmo_latency got=%0d exp=%0d", last_done_cyc - last_start_cyc, TMO + CSH + 1); end
    checks++; if (rx_cnt[1] != 0 || ss_n !== 4'b1111 || ss_err != 0) begin failures++;
      $display("FAIL tmo_release got rx=%0d ss=%b sserr=%0d exp 0/1111/0", rx_cnt[1], ss_n, ss_err); end
  endtask

  task automatic test_req_drop();
    bit ok;
    clear_stats();
    m_dmax = 2;
    drop_on_grant = 1;
    load_req(3, 1, 1, 0);
    req[3] = 1'b1;
    run_until(1, 300, ok);
    model_last = 3;
    checks++; if (!ok || pop_cnt[3] != 2 || rx_cnt[3] != 2 || done_cnt[3] != 1) begin failures++;
      $display("FAIL drop_counts got pop=%0d rx=%0d done=%0d exp 2/2/1", pop_cnt[3], rx_cnt[3], done_cnt[3]); end
    checks++; if (ss_err + gap_err + data_err + rx_err != 0) begin failures++;
      $display("FAIL drop_protocol got ss=%0d gap=%0d data=%0d rx=%0d exp=0", ss_err, gap_err, data_err, rx_err); end
  endtask

  task automatic test_random();
    bit ok, cnt_ok;
    logic [N-1:0] mask, rem;
    int lens [N];
    int exp_q [$];
    for (int r = 0; r < 6; r++) begin
      clear_stats();
      m_noise = 1; m_loop = 1'($urandom); m_dmax = 3;
      mask = N'($urandom_range(15, 1));
      for (int i = 0; i < N; i++) begin
        lens[i] = $urandom_range(3, 0);
        if (mask[i]) load_req(i, lens[i], 1, 0);
      end
      exp_q.delete();
      rem = mask;
      while (rem != 0) begin model_last = rr_next(model_last, rem); rem[model_last] = 1'b0; exp_q.push_back(model_last); end
      req = mask;
      run_until($countones(mask), 2000, ok);
      cnt_ok = 1;
      for (int i = 0; i < N; i++) begin
        if (pop_cnt[i] != (mask[i] ? lens[i] + 1 : 0) || rx_cnt[i] != (mask[i] ? lens[i] + 1 : 0)) cnt_ok = 0;
        if (done_cnt[i] != int'(mask[i]) || err_cnt[i] != 0) cnt_ok = 0;
      end
      checks++; if (!ok || grant_log != exp_q) begin failures++;
        $display("FAIL rand_order r=%0d got=%p exp=%p", r, grant_log, exp_q); end
      checks++; if (!cnt_ok) begin failures++;
        $display("FAIL rand_counts r=%0d got pops=%p rx=%p mask=%b", r, pop_cnt, rx_cnt, mask); end
      checks++; if (ss_err + gap_err + data_err + rx_err != 0) begin failures++;
        $display("FAIL rand_protocol r=%0d got ss=%0d gap=%0d data=%0d rx=%0d exp=0", r, ss_err, gap_err, data_err, rx_err); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int k;
    clear_stats();
    m_fix = 8;
    load_req(2, 2, 1, 0);
    req[2] = 1'b1;
    k = 0;
    while (start_cnt < 2 && k < 300) begin step(); k++; end
    checks++; if (start_cnt != 2) begin failures++; $display("FAIL rmid_reach got=%0d starts exp=2", start_cnt); end
    repeat (3) step();
    #3 rst = 1'b1;
    #1;
    checks++; if (ss_n !== 4'b1111 || grant !== 4'b0 || start !== 1'b0) begin failures++;
      $display("FAIL rmid_async got ss=%b grant=%b start=%b exp 1111/0000/0", ss_n, grant, start); end
    clear_stats();
    req = '0;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();
    checks++; if (done_total != 0 || tx_pop !== '0 || mosi_data !== 8'h00) begin failures++;
      $display("FAIL rmid_quiet got done=%0d pop=%b data=%h exp 0/0000/00", done_total, tx_pop, mosi_data); end
    model_last = N - 1;
    load_req(0, 0, 1, 0);
    load_req(3, 0, 1, 0);
    req = 4'b1001;
    run_until(2, 600, ok);
    checks++; if (!ok || grant_log.size() != 2 || grant_log[0] != rr_next(N - 1, 4'b1001) || grant_log[1] != 3) begin
      failures++; $display("FAIL rmid_restart got=%p exp first=%0d then 3", grant_log, rr_next(N - 1, 4'b1001)); end
    model_last = 3;
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_fairness();
    test_single();
    test_burst();
    test_timeout();
    test_req_drop();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
